pll_reset_sequencer: RTL and testbench



---
 rtl/pll_seq_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/pll_reset_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding and default timing for the PLL reset sequencer.
// Imported by pll_reset_sequencer and any debug logic that decodes its state.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_seq_state_t;

    localparam int DEF_RST_CYCLES     = 16;
    localparam int DEF_STABLE_CYCLES  = 1024;
    localparam int DEF_TIMEOUT_CYCLES = 742500;
    localparam int DEF_MAX_RETRIES    = 3;

    // Core reset is released only while the sequencer is in RUN.
    function automatic logic holds_core(input pll_seq_state_t s);
        return s != RUN;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for slow level signals entering a clock domain.
// Also used for bridge-side control levels; output is cleared by synchronous reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back flops give metastability settling time before use.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: PLL reset pulse, lock qualification, core reset release.
// Define PLL_LOCK_TIMEOUT_EN for the WAIT_LOCK timeout, retry count and FAULT state.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES     = DEF_RST_CYCLES,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
    input  logic       clk_74a,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       restart_req,
    output logic       restart_ack,
    output logic       pll_rst,
    output logic       core_reset,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retry_count,
    output logic [2:0] state
);

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
    localparam logic [SW-1:0] STB_LAST = SW'(STABLE_CYCLES - 1);

    logic           locked_s;
    logic           req_q;
    logic           accept;
    pll_seq_state_t cur;
    pll_seq_state_t nxt;
    logic [RW-1:0]  rst_cnt;
    logic [RW-1:0]  rst_cnt_n;
    logic [SW-1:0]  stb_cnt;
    logic [SW-1:0]  stb_cnt_n;

`ifdef PLL_LOCK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRIES);

    logic [TW-1:0] to_cnt;
    logic [TW-1:0] to_cnt_n;
    logic [1:0]    retry_q;
    logic [1:0]    retry_n;
    logic          fault_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{TIMEOUT_CYCLES, MAX_RETRIES};
`endif

    sync_2ff #(
        .WIDTH(1)
    ) u_lock_sync (
        .clk(clk_74a),
        .rst(rst),
        .d  (pll_locked),
        .q  (locked_s)
    );

    // A restart is taken only on a low-to-high change of the request level.
    assign accept = restart_req & ~req_q;

    // Next state and counter updates; restart outranks lock and timeout events.
    always_comb begin
        nxt       = cur;
        rst_cnt_n = rst_cnt;
        stb_cnt_n = stb_cnt;
`ifdef PLL_LOCK_TIMEOUT_EN
        to_cnt_n  = to_cnt;
        retry_n   = retry_q;
`endif
        if (accept) begin
            nxt       = PLL_RESET;
            rst_cnt_n = '0;
            stb_cnt_n = '0;
`ifdef PLL_LOCK_TIMEOUT_EN
            to_cnt_n  = '0;
            retry_n   = '0;
`endif
        end else begin
            unique case (cur)
                PLL_RESET: begin
                    if (rst_cnt == RST_LAST) begin
                        nxt = WAIT_LOCK;
`ifdef PLL_LOCK_TIMEOUT_EN
                        to_cnt_n = '0;
`endif
                    end else begin
                        rst_cnt_n = rst_cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        nxt       = STABLE;
                        stb_cnt_n = '0;
`ifdef PLL_LOCK_TIMEOUT_EN
                    end else if (to_cnt == TO_LAST) begin
                        if (retry_q < RETRY_MAX) begin
                            retry_n   = retry_q + 2'd1;
                            nxt       = PLL_RESET;
                            rst_cnt_n = '0;
                        end else begin
                            nxt = FAULT;
                        end
                    end else begin
                        to_cnt_n = to_cnt + 1'b1;
`endif
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        nxt = WAIT_LOCK;
`ifdef PLL_LOCK_TIMEOUT_EN
                        to_cnt_n = '0;
`endif
                    end else if (stb_cnt == STB_LAST) begin
                        nxt = RUN;
                    end else begin
                        stb_cnt_n = stb_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        nxt       = PLL_RESET;
                        rst_cnt_n = '0;
                    end
                end
`ifdef PLL_LOCK_TIMEOUT_EN
                FAULT: begin
                    nxt = FAULT;
                end
`endif
                default: begin
                    nxt       = PLL_RESET;
                    rst_cnt_n = '0;
                end
            endcase
        end
    end

    // State, counters and glitch-free outputs decoded from the next state.
    always_ff @(posedge clk_74a) begin
        req_q <= restart_req;
        if (rst) begin
            cur         <= PLL_RESET;
            rst_cnt     <= '0;
            stb_cnt     <= '0;
            restart_ack <= 1'b0;
            pll_rst     <= 1'b1;
            core_reset  <= 1'b1;
            ready       <= 1'b0;
`ifdef PLL_LOCK_TIMEOUT_EN
            to_cnt      <= '0;
            retry_q     <= '0;
            fault_q     <= 1'b0;
`endif
        end else begin
            cur         <= nxt;
            rst_cnt     <= rst_cnt_n;
            stb_cnt     <= stb_cnt_n;
            restart_ack <= accept;
            pll_rst     <= (nxt == PLL_RESET);
            core_reset  <= holds_core(nxt);
            ready       <= (nxt == RUN);
`ifdef PLL_LOCK_TIMEOUT_EN
            to_cnt      <= to_cnt_n;
            retry_q     <= retry_n;
            fault_q     <= (nxt == FAULT);
`endif
        end
    end

    assign state = cur;

`ifdef PLL_LOCK_TIMEOUT_EN
    assign fault       = fault_q;
    assign retry_count = retry_q;
`else
    assign fault       = 1'b0;
    assign retry_count = 2'b00;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: scenario tasks with randomized delays; expected
// edge positions are derived arithmetically from the sequencing rules.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

    localparam int R = 4;
    localparam int S = 8;
    localparam int T = 32;
    localparam int M = 2;

    localparam logic [2:0] S_RST  = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_STB  = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_FLT  = 3'd4;

    logic       clk_74a = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       restart_req = 1'b0;
    logic       restart_ack;
    logic       pll_rst;
    logic       core_reset;
    logic       ready;
    logic       fault;
    logic [1:0] retry_count;
    logic [2:0] state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    pll_reset_sequencer #(
        .RST_CYCLES    (R),
        .STABLE_CYCLES (S),
        .TIMEOUT_CYCLES(T),
        .MAX_RETRIES   (M)
    ) dut (
        .clk_74a    (clk_74a),
        .rst        (rst),
        .pll_locked (pll_locked),
        .restart_req(restart_req),
        .restart_ack(restart_ack),
        .pll_rst    (pll_rst),
        .core_reset (core_reset),
        .ready      (ready),
        .fault      (fault),
        .retry_count(retry_count),
        .state      (state)
    );

    always #5 clk_74a = ~clk_74a;

    always @(posedge clk_74a) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_74a);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pll_locked = 1'b0;
        restart_req = 1'b0;
        step(3);
        checks++;
        if ({pll_rst, core_reset, ready, fault, restart_ack} !== 5'b11000) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 11000",
                     {pll_rst, core_reset, ready, fault, restart_ack});
        end
        checks++;
        if (retry_count !== 2'd0) begin
            failures++;
            $display("FAIL reset_retry: got %0d expected 0", retry_count);
        end
        checks++;
        if (state !== S_RST) begin
            failures++;
            $display("FAIL reset_state: got %0d expected %0d", state, S_RST);
        end
    endtask

    task automatic test_powerup();
        int n, e0, t;
        rst = 1'b0;
        e0 = cyc;
        n = 0;
        while (pll_rst === 1'b1 && n < 50) begin
            n++;
            step(1);
        end
        checks++;
        if (n != R) begin
            failures++;
            $display("FAIL pwr_pll_rst_len: got %0d expected %0d", n, R);
        end
        step(10 - (cyc - e0));
        pll_locked = 1'b1;
        t = cyc;
        while (core_reset === 1'b1 && cyc - t < 200) step(1);
        checks++;
        if (cyc - t != 3 + S) begin
            failures++;
            $display("FAIL pwr_release: got %0d expected %0d", cyc - t, 3 + S);
        end
        checks++;
        if ({ready, pll_rst, retry_count, state} !== {1'b1, 1'b0, 2'd0, S_RUN}) begin
            failures++;
            $display("FAIL pwr_run_out: got %b expected %b",
                     {ready, pll_rst, retry_count, state},
                     {1'b1, 1'b0, 2'd0, S_RUN});
        end
    endtask

    task automatic test_lock_glitch();
        for (int it = 0; it < 3; it++) begin
            int k, w, t, g, fw, seen, n;
            k = (it == 0) ? 5 : int'($urandom_range(S - 3, 0));
            w = (it == 0) ? 1 : int'($urandom_range(3, 1));
            pll_locked = 1'b0;
            n = 0;
            while (state !== S_WAIT && n < 50) begin
                step(1);
                n++;
            end
            step(int'($urandom_range(5, 0)));
            pll_locked = 1'b1;
            t = cyc;
            step(3 + k);
            checks++;
            if (state !== S_STB) begin
                failures++;
                $display("FAIL glitch_in_stable: got %0d expected %0d", state, S_STB);
            end
            g = cyc;
            pll_locked = 1'b0;
            fw = -1;
            seen = 0;
            while (core_reset === 1'b1 && cyc - g < 200) begin
                step(1);
                if (cyc - g == w) pll_locked = 1'b1;
                if (state === S_WAIT && fw < 0) fw = cyc - g;
                if (pll_rst !== 1'b0) seen = 1;
            end
            checks++;
            if (fw != 3) begin
                failures++;
                $display("FAIL glitch_wait_edge: got %0d expected 3", fw);
            end
            checks++;
            if (seen != 0) begin
                failures++;
                $display("FAIL glitch_pll_rst: got %0d expected 0", seen);
            end
            checks++;
            if (cyc - g != w + 3 + S) begin
                failures++;
                $display("FAIL glitch_release: got %0d expected %0d", cyc - g, w + 3 + S);
            end
        end
    endtask

    task automatic test_lock_loss();
        for (int it = 0; it < 3; it++) begin
            int r, t, rise, high, exp_rel, stb_entry;
            logic rst_at_rise;
            r = int'($urandom_range(15, 1));
            t = cyc;
            pll_locked = 1'b0;
            rise = -1;
            high = 0;
            rst_at_rise = 1'b0;
            while ((rise < 0 || core_reset === 1'b1) && cyc - t < 200) begin
                step(1);
                if (cyc - t == r) pll_locked = 1'b1;
                if (core_reset === 1'b1 && rise < 0) begin
                    rise = cyc - t;
                    rst_at_rise = pll_rst;
                end
                if (pll_rst === 1'b1) high++;
            end
            stb_entry = (r + 3 > 3 + R + 1) ? r + 3 : 3 + R + 1;
            exp_rel = stb_entry + S;
            checks++;
            if (rise != 3) begin
                failures++;
                $display("FAIL loss_core_rst_edge: got %0d expected 3", rise);
            end
            checks++;
            if (rst_at_rise !== 1'b1) begin
                failures++;
                $display("FAIL loss_pll_rst_edge: got %b expected 1", rst_at_rise);
            end
            checks++;
            if (high != R) begin
                failures++;
                $display("FAIL loss_pll_rst_len: got %0d expected %0d", high, R);
            end
            checks++;
            if (cyc - t != exp_rel || ready !== 1'b1) begin
                failures++;
                $display("FAIL loss_release: got %0d ready=%b expected %0d ready=1",
                         cyc - t, ready, exp_rel);
            end
        end
    endtask

    task automatic test_handshake();
        int t, acks, first_ack, high, run_at, j, a, ack_at, low_at;
        logic [2:0] ack_state;
        t = cyc;
        restart_req = 1'b1;
        acks = 0;
        first_ack = -1;
        ack_state = 3'd7;
        high = 0;
        run_at = -1;
        while (cyc - t < 40) begin
            step(1);
            if (cyc - t == 20) restart_req = 1'b0;
            if (restart_ack === 1'b1) begin
                acks++;
                if (first_ack < 0) begin
                    first_ack = cyc - t;
                    ack_state = state;
                end
            end
            if (pll_rst === 1'b1) high++;
            if (ready === 1'b1 && run_at < 0 && first_ack >= 0) run_at = cyc - t;
        end
        checks++;
        if (acks != 1 || first_ack != 1) begin
            failures++;
            $display("FAIL hs_level_ack: got %0d pulses at %0d expected 1 at 1", acks, first_ack);
        end
        checks++;
        if (ack_state !== S_RST) begin
            failures++;
            $display("FAIL hs_ack_state: got %0d expected %0d", ack_state, S_RST);
        end
        checks++;
        if (high != R || run_at != 1 + R + 1 + S) begin
            failures++;
            $display("FAIL hs_sequence: got pll_rst=%0d run=%0d expected %0d %0d",
                     high, run_at, R, 1 + R + 1 + S);
        end

        j = int'($urandom_range(R - 2, 1));
        t = cyc;
        restart_req = 1'b1;
        step(1);
        checks++;
        if (restart_ack !== 1'b1 || state !== S_RST) begin
            failures++;
            $display("FAIL hs_second_ack: got ack=%b state=%0d expected 1 0", restart_ack, state);
        end
        restart_req = 1'b0;
        step(j);
        restart_req = 1'b1;
        a = cyc + 1;
        acks = 0;
        ack_at = -1;
        low_at = -1;
        run_at = -1;
        while (cyc - t < 60) begin
            step(1);
            if (cyc == a) restart_req = 1'b0;
            if (restart_ack === 1'b1) begin
                acks++;
                ack_at = cyc;
            end
            if (pll_rst === 1'b0 && low_at < 0) low_at = cyc;
            if (ready === 1'b1 && run_at < 0) run_at = cyc;
        end
        checks++;
        if (acks != 1 || ack_at != a) begin
            failures++;
            $display("FAIL hs_rst_restart_ack: got %0d at %0d expected 1 at %0d", acks, ack_at - t, a - t);
        end
        checks++;
        if (low_at != a + R) begin
            failures++;
            $display("FAIL hs_rst_recount: got %0d expected %0d", low_at - t, a + R - t);
        end
        checks++;
        if (run_at != a + R + 1 + S) begin
            failures++;
            $display("FAIL hs_rst_release: got %0d expected %0d", run_at - t, a + R + 1 + S - t);
        end
    endtask

`ifdef PLL_LOCK_TIMEOUT_EN
    task automatic test_timeout();
        int a, rc1, rc2, flt, dwell;
        logic [2:0] rc1_state;
        pll_locked = 1'b0;
        restart_req = 1'b1;
        step(1);
        a = cyc;
        restart_req = 1'b0;
        checks++;
        if (restart_ack !== 1'b1) begin
            failures++;
            $display("FAIL to_start_ack: got %b expected 1", restart_ack);
        end
        rc1 = -1;
        rc2 = -1;
        flt = -1;
        rc1_state = 3'd7;
        while (flt < 0 && cyc - a < 4 * (R + T) + 20) begin
            step(1);
            if (retry_count === 2'd1 && rc1 < 0) begin
                rc1 = cyc - a;
                rc1_state = state;
            end
            if (retry_count === 2'd2 && rc2 < 0) rc2 = cyc - a;
            if (state === S_FLT) flt = cyc - a;
        end
        checks++;
        if (rc1 != R + T || rc1_state !== S_RST) begin
            failures++;
            $display("FAIL to_retry1: got %0d state=%0d expected %0d state=0", rc1, rc1_state, R + T);
        end
        checks++;
        if (rc2 != 2 * (R + T)) begin
            failures++;
            $display("FAIL to_retry2: got %0d expected %0d", rc2, 2 * (R + T));
        end
        checks++;
        if (flt != (M + 1) * (R + T)) begin
            failures++;
            $display("FAIL to_fault_edge: got %0d expected %0d", flt, (M + 1) * (R + T));
        end
        checks++;
        if ({fault, core_reset, pll_rst, ready, retry_count} !== {4'b1100, 2'(M)}) begin
            failures++;
            $display("FAIL to_fault_out: got %b expected %b",
                     {fault, core_reset, pll_rst, ready, retry_count}, {4'b1100, 2'(M)});
        end
        dwell = int'($urandom_range(50, 5));
        step(dwell);
        checks++;
        if (state !== S_FLT || fault !== 1'b1) begin
            failures++;
            $display("FAIL to_fault_hold: got state=%0d fault=%b expected 4 1", state, fault);
        end
        restart_req = 1'b1;
        step(1);
        checks++;
        if ({restart_ack, retry_count, state, fault} !== {1'b1, 2'd0, S_RST, 1'b0}) begin
            failures++;
            $display("FAIL to_fault_restart: got %b expected %b",
                     {restart_ack, retry_count, state, fault}, {1'b1, 2'd0, S_RST, 1'b0});
        end
        restart_req = 1'b0;
        step(1);
        checks++;
        if (restart_ack !== 1'b0) begin
            failures++;
            $display("FAIL to_ack_width: got %b expected 0", restart_ack);
        end
    endtask

    task automatic test_restart_vs_timeout();
        int a;
        restart_req = 1'b1;
        step(1);
        a = cyc;
        restart_req = 1'b0;
        step(a + R + T - 1 - cyc);
        checks++;
        if (state !== S_WAIT) begin
            failures++;
            $display("FAIL rvt_pre_state: got %0d expected %0d", state, S_WAIT);
        end
        restart_req = 1'b1;
        step(1);
        restart_req = 1'b0;
        checks++;
        if ({restart_ack, retry_count, state} !== {1'b1, 2'd0, S_RST}) begin
            failures++;
            $display("FAIL rvt_restart_wins: got %b expected %b",
                     {restart_ack, retry_count, state}, {1'b1, 2'd0, S_RST});
        end
        step(R + T);
        checks++;
        if (retry_count !== 2'd1 || state !== S_RST) begin
            failures++;
            $display("FAIL rvt_next_timeout: got rc=%0d state=%0d expected 1 0", retry_count, state);
        end
        pll_locked = 1'b1;
        step(R + S + 10);
    endtask
`else
    task automatic test_no_timeout();
        int t, bad;
        pll_locked = 1'b0;
        step(3 + R);
        checks++;
        if (state !== S_WAIT) begin
            failures++;
            $display("FAIL nt_enter_wait: got %0d expected %0d", state, S_WAIT);
        end
        bad = 0;
        repeat (1000) begin
            step(1);
            if (state !== S_WAIT || fault !== 1'b0 || retry_count !== 2'd0 || pll_rst !== 1'b0)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL nt_hold_wait: got %0d bad cycles expected 0", bad);
        end
        pll_locked = 1'b1;
        t = cyc;
        while (core_reset === 1'b1 && cyc - t < 200) step(1);
        checks++;
        if (cyc - t != 3 + S) begin
            failures++;
            $display("FAIL nt_release: got %0d expected %0d", cyc - t, 3 + S);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_powerup();
        test_lock_glitch();
        test_lock_loss();
        test_handshake();
`ifdef PLL_LOCK_TIMEOUT_EN
        test_timeout();
        test_restart_vs_timeout();
`else
        test_no_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
